alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; power of two, 8..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 alu_op  input  4  operation code, sampled on accept.
REQ-005 a  input  WIDTH  first operand.
REQ-006 b  input  WIDTH  second operand / shift amount.
REQ-007 imm  input  WIDTH  immediate operand for ADDI.
REQ-008 in_valid  input  1  request present.
REQ-009 in_ready  output  1  block can accept a request.
REQ-010 result  output  WIDTH  registered result.
REQ-011 flag_z / flag_n / flag_c  output  1 each  zero, negative (result MSB), carry.
REQ-012 out_valid  output  1  result and flags valid.
REQ-013 out_ready  input  1  consumer accepts result.

Function
REQ-014 Opcodes SHALL be: 0000 ADD a+b; 0001 ADDI a+imm; 0010 LSL a<<b; 0011 SUB a-b; 0100 LSR logical a>>b; 0101 ASR arithmetic a>>>b; 0110 MUL low WIDTH bits of a*b; all others result 0, flags from that 0, flag_c 0.
REQ-015 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; operands and opcode SHALL be captured in internal registers at accept.
REQ-016 FSM states SHALL be IDLE, MUL, DONE; in_ready=1 only in IDLE (no accept while busy, no same-cycle bypass).
REQ-017 IDLE: on accept of a non-MUL op, result/flags SHALL be registered and state -> DONE, out_valid=1 the next cycle (latency 1).
REQ-018 IDLE: on accept of MUL, state -> MUL; shift-add, one multiplier bit per cycle, exactly WIDTH cycles in MUL, then DONE (out_valid asserted WIDTH+1 cycles after accept).
REQ-019 DONE: result, flags, out_valid SHALL hold stable until out_ready=1; on that edge state -> IDLE, out_valid -> 0.
REQ-020 Shift amount SHALL be full b value: b>=WIDTH gives 0 for LSL/LSR and WIDTH copies of a's MSB for ASR.
REQ-021 Arithmetic modulo 2^WIDTH; flag_c = carry-out for ADD/ADDI, borrow (a<b unsigned) for SUB, last bit shifted out for LSL/LSR/ASR with 0<b<=WIDTH else 0, 0 for MUL.
REQ-022 flag_z = (result==0); flag_n = result[WIDTH-1]; all flags registered with result.
REQ-023 out_ready while out_valid=0 SHALL be ignored; in_valid while in_ready=0 SHALL be ignored (requester must hold).

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, result 0, flags 0, out_valid 0, MUL counter/accumulator 0; in_ready=1 on deassertion.
REQ-025 Reset mid-MUL or in DONE SHALL discard the operation with no result delivered.

Structure
REQ-026 Shared package SHALL hold the 4-bit opcode constants (ADD..MUL) and the FSM state enum; opcode values identical to existing ALU encoding.
REQ-027 One sub-module natural: alu_mc_comb (combinational single-cycle datapath: add/sub/shifts and flags), instantiated once; MUL sequencing stays in alu_mc.

Verification
REQ-028 WIDTH=32, ADD a=0xFFFFFFFF b=1 -> one cycle later result 0, flag_z=1, flag_c=1, out_valid=1.
REQ-029 SUB a=5 b=7 -> result 0xFFFFFFFE, flag_n=1, flag_c=1; ADDI a=10 imm=9 -> 19.
REQ-030 ASR a=0x80000000 b=40 -> 0xFFFFFFFF; LSL a=1 b=32 -> 0, flag_c=1 at b=32, flag_c=0 at b=33; LSR a=0x10 b=4 -> 1.
REQ-031 MUL a=123 b=456 -> out_valid exactly 33 cycles after accept, result 56088; in_ready=0 throughout; second in_valid during MUL not accepted.
REQ-032 Backpressure: out_ready=0 for 5 cycles after result -> result/flags stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-033 rst_n pulsed low at MUL cycle 10 -> out_valid stays 0, in_ready=1 after release, next ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - shared opcode encodings and FSM state type for alu_mc
//
// Purpose: single source for the 4-bit ALU opcode values and the control FSM
//          state enum used by alu_mc and alu_mc_comb.
// Ports:   none (package).

package alu_mc_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_LSL  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_LSR  = 4'b0100;
    localparam logic [3:0] OP_ASR  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mc_comb.sv
// rtl/alu_mc_comb.sv - single-cycle ALU datapath (add/sub/shifts) with carry
//
// Purpose: purely combinational result and carry for every opcode except MUL,
//          which is sequenced by alu_mc. MUL and undefined opcodes give 0.
// Ports:
//   op     in  4      operation code
//   a      in  WIDTH  first operand
//   b      in  WIDTH  second operand / shift amount
//   imm    in  WIDTH  immediate operand for ADDI
//   res    out WIDTH  result
//   carry  out 1      carry / borrow / last bit shifted out

module alu_mc_comb
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    localparam int SW = $clog2(WIDTH);

    logic               big;
    logic [SW:0]        sh;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] lsl_x;
    logic [2*WIDTH-1:0] lsr_x;
    logic [2*WIDTH-1:0] asr_x;

    // Shifts run on a double-width vector so the bit just past the result
    // boundary is the last bit shifted out; this covers shift == WIDTH too.
    // Amounts above WIDTH are handled separately via 'big'.
    always_comb begin
        big    = (|b[WIDTH-1:SW+1]) | (b[SW] & (|b[SW-1:0]));
        sh     = b[SW:0];
        addend = (op == OP_ADDI) ? imm : b;
        sum    = {1'b0, a} + {1'b0, addend};
        lsl_x  = {{WIDTH{1'b0}}, a} << sh;
        lsr_x  = {a, {WIDTH{1'b0}}} >> sh;
        asr_x  = $signed({a, {WIDTH{1'b0}}}) >>> sh;

        res   = '0;
        carry = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SUB: begin
                res   = a - b;
                carry = (a < b);
            end
            OP_LSL: begin
                if (!big) begin
                    res   = lsl_x[WIDTH-1:0];
                    carry = lsl_x[WIDTH];
                end
            end
            OP_LSR: begin
                if (!big) begin
                    res   = lsr_x[2*WIDTH-1:WIDTH];
                    carry = lsr_x[WIDTH-1];
                end
            end
            OP_ASR: begin
                if (big) begin
                    res = {WIDTH{a[WIDTH-1]}};
                end else begin
                    res   = asr_x[2*WIDTH-1:WIDTH];
                    carry = asr_x[WIDTH-1];
                end
            end
            default: begin
                res   = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake and shift-add MUL
//
// Purpose: accepts one request at a time in IDLE; single-cycle ops complete in
//          one cycle, MUL takes WIDTH shift-add cycles; result held in DONE
//          until the consumer takes it.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   alu_op, a, b, imm       request opcode and operands
//   in_valid / in_ready     request handshake
//   result                  registered result
//   flag_z, flag_n, flag_c  zero, negative, carry flags (registered)
//   out_valid / out_ready   result handshake

module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] comb_res;
    logic             comb_c;
    logic             accept;
    logic             mul_last;

    alu_mc_comb #(.WIDTH(WIDTH)) u_comb (
        .op    (alu_op),
        .a     (a),
        .b     (b),
        .imm   (imm),
        .res   (comb_res),
        .carry (comb_c)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign mul_last  = (cnt == CNT_LAST);
    assign acc_nxt   = mplier[0] ? (acc + mcand) : acc;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (alu_op == OP_MUL) ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Multiplicand shifts left and multiplier shifts right so each MUL cycle
    // only ever inspects mplier[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        if (alu_op != OP_MUL) begin
                            result <= comb_res;
                            flag_z <= (comb_res == '0);
                            flag_n <= comb_res[WIDTH-1];
                            flag_c <= comb_c;
                        end
                    end
                end
                ST_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (mul_last) begin
                        result <= acc_nxt;
                        flag_z <= (acc_nxt == '0);
                        flag_n <= acc_nxt[WIDTH-1];
                        flag_c <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard testbench for alu_mc

module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   alu_op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] imm;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] result;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
    logic         out_valid;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         c;
        string        name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .imm       (imm),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every completed output handshake is compared to the oldest
    // expectation in the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h required=none", result);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_z"}, W'(flag_z), W'(e.z));
                check({e.name, "_n"}, W'(flag_n), W'(e.n));
                check({e.name, "_c"}, W'(flag_c), W'(e.c));
            end
        end
    end

    // Issue one request, record its expected response and measure the number
    // of cycles from the accept edge until out_valid is seen.
    task automatic issue(input string name, input logic [3:0] op,
                         input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] iv,
                         input logic [W-1:0] er, input logic ez, input logic en, input logic ec,
                         input int lat);
        int n;
        sb.push_back('{er, ez, en, ec, name});
        alu_op   = op;
        a        = av;
        b        = bv;
        imm      = iv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_accept"}, W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (op == OP_MUL) begin
            // stray request while busy: must be ignored
            alu_op   = OP_ADD;
            a        = 32'd1;
            b        = 32'd1;
            in_valid = 1'b1;
        end
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            if (op == OP_MUL) check({name, "_busy_in_ready"}, W'(in_ready), W'(0));
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check({name, "_latency"}, W'(n), W'(lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        alu_op    = OP_ADD;
        a         = '0;
        b         = '0;
        imm       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_result", result, 32'h0);
        check("rst_flags", W'({flag_z, flag_n, flag_c}), W'(0));
        check("rst_in_ready_after", W'(in_ready), W'(1));

        issue("add_wrap", OP_ADD,  32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1, 0, 1, 1);
        issue("sub",      OP_SUB,  32'd5, 32'd7, 32'h0, 32'hFFFFFFFE, 0, 1, 1, 1);
        issue("addi",     OP_ADDI, 32'd10, 32'h55, 32'd9, 32'd19, 0, 0, 0, 1);
        issue("asr_big",  OP_ASR,  32'h80000000, 32'd40, 32'h0, 32'hFFFFFFFF, 0, 1, 0, 1);
        issue("lsl_32",   OP_LSL,  32'h1, 32'd32, 32'h0, 32'h0, 1, 0, 1, 1);
        issue("lsl_33",   OP_LSL,  32'h1, 32'd33, 32'h0, 32'h0, 1, 0, 0, 1);
        issue("lsr_4",    OP_LSR,  32'h10, 32'd4, 32'h0, 32'h1, 0, 0, 0, 1);
        issue("lsl_1",    OP_LSL,  32'h80000001, 32'd1, 32'h0, 32'h2, 0, 0, 1, 1);
        issue("asr_4",    OP_ASR,  32'h80000018, 32'd4, 32'h0, 32'hF8000001, 0, 1, 1, 1);
        issue("lsr_0",    OP_LSR,  32'h3, 32'd0, 32'h0, 32'h3, 0, 0, 0, 1);
        issue("bad_op",   4'b1111, 32'h5, 32'h5, 32'h0, 32'h0, 1, 0, 0, 1);
        issue("mul",      OP_MUL,  32'd123, 32'd456, 32'h0, 32'd56088, 0, 0, 0, 33);
        issue("mul_ones", OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 0, 0, 0, 33);
        issue("mul_zero", OP_MUL,  32'h10000, 32'h10000, 32'h0, 32'h0, 1, 0, 0, 33);

        // Backpressure: result must hold while out_ready is low.
        @(negedge clk);
        out_ready = 1'b0;
        issue("bp_add", OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h80000000, 0, 1, 0, 1);
        repeat (5) begin
            check("bp_hold_result", result, 32'h80000000);
            check("bp_hold_flags", W'({flag_z, flag_n, flag_c}), W'(3'b010));
            check("bp_hold_valid", W'(out_valid), W'(1));
            check("bp_in_ready", W'(in_ready), W'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", W'(out_valid), W'(0));
        check("bp_release_in_ready", W'(in_ready), W'(1));

        // Reset during MUL discards the operation.
        alu_op   = OP_MUL;
        a        = 32'd7;
        b        = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", W'(out_valid), W'(0));
        check("mrst_in_ready", W'(in_ready), W'(1));
        check("mrst_result", result, 32'h0);
        check("mrst_flags", W'({flag_z, flag_n, flag_c}), W'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_in_ready_after", W'(in_ready), W'(1));
        repeat (40) begin
            check("mrst_no_output", W'(out_valid), W'(0));
            @(negedge clk);
        end
        issue("post_rst_add", OP_ADD, 32'd2, 32'd3, 32'h0, 32'd5, 0, 0, 0, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", W'(sb.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
